// File: rtl/pdm_decimator_mc_if.sv
// PCM output stream of the PDM decimator: data/valid from producer,
// ready from consumer.
interface pdm_decimator_mc_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
);
  logic [CHANNELS*CNT_W-1:0] pcm_data;
  logic                      pcm_valid;
  logic                      pcm_ready;

  modport master (
    output pcm_data,
    output pcm_valid,
    input  pcm_ready
  );

  modport slave (
    input  pcm_data,
    input  pcm_valid,
    output pcm_ready
  );
endinterface

// File: rtl/pdm_decimator_mc.sv
// Multi-channel PDM-to-PCM ones-count decimator with valid/ready output.
// Optional sticky overrun flag enabled by macro PDM_DEC_OVERRUN_EN.
module pdm_decimator_mc #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CNT_W-1:0]    decimation_ratio,
  input  logic [CHANNELS-1:0] pdm_in,
  pdm_decimator_mc_if.master  pcm,
  output logic                dec_clk,
  output logic                overrun
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0] acc_q, acc_d;
  logic [CHANNELS-1:0][CNT_W-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic dclk_q, dclk_d;
  logic [CNT_W-1:0] ratio_eff;
  logic boundary;

  assign ratio_eff = (decimation_ratio == '0) ? ONE
                                              : decimation_ratio;

  // >= so a ratio shrunk under the counter closes at once
  assign boundary = enable && (cnt_q >= r_q - ONE);

  always_comb begin
    r_d     = r_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    dclk_d  = dclk_q;
    if (enable) begin
      cnt_d = boundary ? '0 : cnt_q + ONE;
      for (int k = 0; k < CHANNELS; k++) begin
        acc_d[k] = acc_q[k] + {{(CNT_W-1){1'b0}}, pdm_in[k]};
        if (boundary) begin
          data_d[k] = acc_d[k];
          acc_d[k]  = '0;
        end
      end
    end
    if (boundary || !enable) r_d = ratio_eff;
    if (boundary) begin
      valid_d = 1'b1;
      dclk_d  = ~dclk_q;
    end else if (valid_q && pcm.pcm_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= ONE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      dclk_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      dclk_q  <= dclk_d;
    end
  end

  assign pcm.pcm_data  = data_q;
  assign pcm.pcm_valid = valid_q;
  assign dec_clk       = dclk_q;

`ifdef PDM_DEC_OVERRUN_EN
  logic ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else if (boundary && valid_q && !pcm.pcm_ready) begin
      ovr_q <= 1'b1;
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_decimator_mc.sv
// Self-checking bench for pdm_decimator_mc: directed table, corner
// sequences and randomized traffic against a sample-window model.
module tb_pdm_decimator_mc;

  localparam int CH = 2;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [W-1:0] ratio;
  logic [CH-1:0] pdm;
  logic rdy;
  logic dclk;
  logic ovr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pdm_decimator_mc_if #(.CHANNELS(CH), .CNT_W(W)) pcm_if ();

  assign pcm_if.pcm_ready = rdy;

  pdm_decimator_mc #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (en),
    .decimation_ratio (ratio),
    .pdm_in           (pdm),
    .pcm              (pcm_if.master),
    .dec_clk          (dclk),
    .overrun          (ovr)
  );

  wire [W-1:0] d0 = pcm_if.pcm_data[W-1:0];
  wire [W-1:0] d1 = pcm_if.pcm_data[2*W-1:W];
  wire         vld = pcm_if.pcm_valid;

`ifdef PDM_DEC_OVERRUN_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  // Reference model: collect the window's samples, count ones on close
  logic [CH-1:0] win[$];
  int   m_r;
  logic m_valid, m_dclk, m_ovr;
  logic [W-1:0] m_d0, m_d1;

  task automatic model_reset();
    win.delete();
    m_r = 1;
    m_valid = 0;
    m_dclk = 0;
    m_ovr = 0;
    m_d0 = 0;
    m_d1 = 0;
  endtask

  task automatic model_edge();
    bit close;
    int c0, c1;
    close = 0;
    if (en) begin
      win.push_back(pdm);
      if (win.size() >= m_r) close = 1;
    end
    if (close) begin
      c0 = 0;
      c1 = 0;
      foreach (win[i]) begin
        c0 += int'(win[i][0]);
        c1 += int'(win[i][1]);
      end
      if (m_valid && !rdy && OVR_ON) m_ovr = 1;
      m_d0 = W'(c0);
      m_d1 = W'(c1);
      m_valid = 1;
      m_dclk = ~m_dclk;
      win.delete();
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (close || !en) m_r = (ratio == 0) ? 1 : int'(ratio);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_valid", 32'(vld), 32'(m_valid));
    chk("model_ch0", 32'(d0), 32'(m_d0));
    chk("model_ch1", 32'(d1), 32'(m_d1));
    chk("model_dclk", 32'(dclk), 32'(m_dclk));
    chk("model_ovr", 32'(ovr), 32'(m_ovr));
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_valid", 32'(vld), 0);
    chk("rst_data", 32'(pcm_if.pcm_data), 0);
    chk("rst_dclk", 32'(dclk), 0);
    chk("rst_ovr", 32'(ovr), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic         en;
    logic [W-1:0] ratio;
    logic [1:0]   pdm;
    logic         rdy;
    logic         e_valid;
    logic [W-1:0] e_d0;
    logic [W-1:0] e_d1;
    logic         e_dclk;
  } vec_t;

  vec_t tbl[9];
  int   cnt3;
  logic [1:0] p;

  initial begin
    rst_n = 0;
    en = 0;
    ratio = 1;
    pdm = 0;
    rdy = 1;

    // ratio 4, ch0 all ones, ch1 1,0,1,0
    tbl[0] = '{0, 4, 2'b00, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 4, 2'b11, 1, 0, 0, 0, 0};
    tbl[2] = '{1, 4, 2'b01, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 4, 2'b11, 1, 0, 0, 0, 0};
    tbl[4] = '{1, 4, 2'b01, 1, 1, 4, 2, 1};
    tbl[5] = '{1, 4, 2'b11, 1, 0, 4, 2, 1};
    tbl[6] = '{1, 4, 2'b01, 1, 0, 4, 2, 1};
    tbl[7] = '{1, 4, 2'b11, 1, 0, 4, 2, 1};
    tbl[8] = '{1, 4, 2'b01, 1, 1, 4, 2, 0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en;
      ratio = tbl[i].ratio;
      pdm = tbl[i].pdm;
      rdy = tbl[i].rdy;
      tick();
      chk("tbl_valid", 32'(vld), 32'(tbl[i].e_valid));
      chk("tbl_ch0", 32'(d0), 32'(tbl[i].e_d0));
      chk("tbl_ch1", 32'(d1), 32'(tbl[i].e_d1));
      chk("tbl_dclk", 32'(dclk), 32'(tbl[i].e_dclk));
    end

    // ratio 1: every enabled sample is a word
    do_reset();
    en = 0;
    ratio = 1;
    tick();
    en = 1;
    rdy = 1;
    for (int i = 0; i < 10; i++) begin
      pdm = {1'b0, 1'(i % 2)};
      tick();
      chk("r1_valid", 32'(vld), 1);
      chk("r1_ch0", 32'(d0), 32'(pdm[0]));
    end

    // ratio 8, consumer stalled for three windows
    do_reset();
    en = 0;
    ratio = 8;
    rdy = 0;
    tick();
    en = 1;
    cnt3 = 0;
    for (int i = 0; i < 24; i++) begin
      pdm = 2'($urandom);
      if (i >= 16) cnt3 += int'(pdm[0]);
      tick();
      if (i == 7) chk("ovr_after_b1", 32'(ovr), 0);
      if (i == 15) chk("ovr_after_b2", 32'(ovr), 32'(OVR_ON));
    end
    chk("ovr_valid", 32'(vld), 1);
    chk("ovr_ch0_win3", 32'(d0), 32'(cnt3));
    chk("ovr_final", 32'(ovr), 32'(OVR_ON));
    rdy = 1;

    // ratio 4 -> 6 after two samples of a window
    do_reset();
    en = 0;
    ratio = 4;
    tick();
    en = 1;
    pdm = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) ratio = 6;
      tick();
      if (i == 4) begin
        chk("rc_valid4", 32'(vld), 1);
        chk("rc_ch0_4", 32'(d0), 4);
      end else if (i == 10) begin
        chk("rc_valid6", 32'(vld), 1);
        chk("rc_ch0_6", 32'(d0), 6);
      end else begin
        chk("rc_idle", 32'(vld), 0);
      end
    end

    // enable low for 5 cycles mid-window
    do_reset();
    en = 0;
    ratio = 4;
    tick();
    for (int i = 0; i < 9; i++) begin
      en = !(i >= 2 && i < 7);
      pdm = en ? 2'b01 : 2'b11;
      tick();
      if (i < 8) chk("frz_idle", 32'(vld), 0);
    end
    chk("frz_valid", 32'(vld), 1);
    chk("frz_ch0", 32'(d0), 4);
    chk("frz_ch1", 32'(d1), 0);

    // reset mid-window after 3 of 8 samples
    do_reset();
    en = 0;
    ratio = 8;
    tick();
    en = 1;
    pdm = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    do_reset();
    en = 0;
    tick();
    en = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("prst_valid", 32'(vld), (i == 8) ? 1 : 0);
    end
    chk("prst_ch0", 32'(d0), 8);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) ratio = W'($urandom % 6);
      rdy = 1'($urandom);
      pdm = 2'($urandom);
      if (($urandom % 200) == 0) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pdm_decimator_mc.md
PDM_DECIMATOR_MC -- requirements
Module: pdm_decimator_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent PDM input channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-channel PCM result and of the ratio.
REQ-003 SHALL have port clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  when high, a PDM sample is taken this cycle; when low, sampling state holds.
REQ-006 SHALL have port decimation_ratio  input  CNT_W  the number of PDM samples per output word; values 0 and 1 both mean 1.
REQ-007 SHALL have port pdm_in  input  CHANNELS  one PDM bit per channel; channel k is bit k.
REQ-008 SHALL have port pcm_data  output  CHANNELS*CNT_W  the ones-count per channel; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-009 SHALL have port pcm_valid  output  1  high when pcm_data holds an unconsumed word.
REQ-010 SHALL have port pcm_ready  input  1  consumer accept; a word transfers on a cycle with pcm_valid and pcm_ready both high.
REQ-011 SHALL have port dec_clk  output  1  toggles once per completed window (square wave at window rate/2).
REQ-012 SHALL have port overrun  output  1  sticky flag: a completed window replaced an unconsumed word.

Function
REQ-013 SHALL keep an active ratio R_q, loaded from decimation_ratio (0 mapped to 1) on every window boundary and on every cycle with enable low; mid-window changes take effect only at the next boundary.
REQ-014 SHALL keep a sample counter 0..R_q-1 and, per channel, an accumulator of CNT_W bits, both advancing only on enabled cycles.
REQ-015 SHALL treat an enabled cycle with counter == R_q-1 as a window boundary: the counter and accumulators return to 0.
REQ-016 SHALL, on a boundary, register pcm_data[k] = accumulator[k] + pdm_in[k] (the sample taken on the boundary cycle is included) and set pcm_valid the next cycle (latency 1 clock after the R-th sample).
REQ-017 SHALL, with R_q == 1, make every enabled cycle a boundary, so pcm_data[k] = {0...,pdm_in[k]}, with pcm_valid set every enabled cycle.
REQ-018 SHALL clear pcm_valid after a transfer unless a boundary occurs in the same cycle, in which case pcm_valid stays high with the new data.
REQ-019 SHALL, when a boundary occurs while pcm_valid is high and pcm_ready is low, overwrite pcm_data with the new word (newest-wins) and set overrun.
REQ-020 SHALL hold pcm_data stable while pcm_valid is high and no boundary occurs.
REQ-021 SHALL toggle dec_clk on the cycle after each boundary, aligned with the pcm_data update.
REQ-022 SHALL keep the handshake (REQ-018) operating while enable is low; only sampling freezes.
REQ-023 SHALL never let an accumulator wrap: the maximum count equals R_q, which is at most 2^CNT_W-1.

Reset
REQ-024 SHALL, while rst_n is low, force counter=0, accumulators=0, R_q=1, pcm_data=0, pcm_valid=0, dec_clk=0, overrun=0, regardless of clk.
REQ-025 SHALL, on reset assertion mid-window, discard the partial window; the first window after release starts at sample 0.
REQ-026 SHALL clear overrun only by reset.

Configuration
REQ-027 SHALL, with macro PDM_DEC_OVERRUN_EN defined, implement the overrun detection of REQ-019 and drive the overrun output from a register.
REQ-028 SHALL, without PDM_DEC_OVERRUN_EN, tie overrun to constant 0 with no flag register; newest-wins overwrite behaviour is unchanged.

Verification
REQ-029 SHALL cover: CHANNELS=2, ratio=4, pcm_ready=1, ch0 all ones, ch1 pattern 1,0,1,0 -> pcm_valid pulses every 4 cycles, ch0=4, ch1=2, dec_clk toggling every 4 cycles.
REQ-030 SHALL cover: ratio=1, pdm_in toggling each cycle -> pcm_valid high continuously, pcm_data ch0 follows pdm_in delayed by 1 clock.
REQ-031 SHALL cover: ratio=8, pcm_ready=0 for 3 windows with macro defined -> pcm_data equals the third window's count, overrun=1 after the second boundary; without macro overrun stays 0.
REQ-032 SHALL cover: ratio changed 4->6 after 2 samples of a window -> that window closes after 4 samples, the next after 6.
REQ-033 SHALL cover: enable low for 5 cycles mid-window at ratio=4 -> counts exclude the frozen cycles; a window boundary still occurs after 4 enabled samples.
REQ-034 SHALL cover: rst_n pulsed low after 3 of 8 samples -> all outputs 0 immediately, first post-reset word appears after 8 fresh enabled samples.
